// File: rtl/vga_timing.sv
// Raster timing source for the VGA drawing pipeline: position counters, sync pulses
// and blanking flags, all registered together so every field describes the same pixel.
module vga_timing #(
    parameter int   H_ACTIVE = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_ACTIVE = 768,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount_o,
    output logic [10:0] vcount_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        hblnk_o,
    output logic        vblnk_o,
    output logic [11:0] rgb_o,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if ((H_TOTAL - 1) > 2047 || (V_TOTAL - 1) > 2047) begin : g_width_check
        $error("vga_timing: H_TOTAL-1 or V_TOTAL-1 does not fit in 11 bits");
    end

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_BLNK_BEG = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_BLNK_BEG = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        frame_start_q, frame_start_d;

    // Flags decode the next position so they land in the same register stage as it.
    always_comb begin
        hcount_d = (hcount_q == H_LAST) ? 11'd0 : hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            vcount_d = (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
        end

        hblnk_d = (hcount_d >= H_BLNK_BEG);
        vblnk_d = (vcount_d >= V_BLNK_BEG);
        hsync_d = ((hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        frame_start_d = (hcount_d == 11'd0) && (vcount_d == 11'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= 11'd0;
            vcount_q      <= 11'd0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Colour is owned entirely by the downstream drawing stages.
    assign rgb_o       = 12'h000;
    assign hcount_o    = hcount_q;
    assign vcount_o    = vcount_q;
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign hblnk_o     = hblnk_q;
    assign vblnk_o     = vblnk_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: a full-size 1024x768 instance for horizontal timing and
// resets, plus a tiny-raster active-low instance so whole frames fit in a short run.
module tb_vga_timing;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Full-size instance (active-high syncs)
    logic [10:0] ha, va;
    logic        hsa, vsa, hba, vba, fsa;
    logic [11:0] rgba;

    vga_timing dut_a (
        .clk(clk), .rst(rst),
        .hcount_o(ha), .vcount_o(va),
        .hsync_o(hsa), .vsync_o(vsa),
        .hblnk_o(hba), .vblnk_o(vba),
        .rgb_o(rgba), .frame_start(fsa)
    );

    // Small instance: H_TOTAL = 16+2+3+4 = 25, V_TOTAL = 6+1+2+3 = 12, frame = 300 clocks
    logic [10:0] hb, vb;
    logic        hsb, vsb, hbb, vbb, fsb;
    logic [11:0] rgbb;

    vga_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .hcount_o(hb), .vcount_o(vb),
        .hsync_o(hsb), .vsync_o(vsb),
        .hblnk_o(hbb), .vblnk_o(vbb),
        .rgb_o(rgbb), .frame_start(fsb)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %-14s got %0d expected %0d ok", tag, obs, exp);
        end else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_a(input int h, input int v, input int budget);
        int n = 0;
        while (!(ha == 11'(h) && va == 11'(v)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_a", {31'd0, (ha == 11'(h) && va == 11'(v))}, 32'd1);
    endtask

    task automatic wait_b(input int h, input int v, input int budget);
        int n = 0;
        while (!(hb == 11'(h) && vb == 11'(v)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_b", {31'd0, (hb == 11'(h) && vb == 11'(v))}, 32'd1);
    endtask

    initial begin
        int t0, t1, n, bad;

        // Reset held for 3 clocks
        step(3);
        chk("rst_hcount", ha, 0);
        chk("rst_vcount", va, 0);
        chk("rst_hblnk", hba, 0);
        chk("rst_vblnk", vba, 0);
        chk("rst_hsync", hsa, 0);
        chk("rst_vsync", vsa, 0);
        chk("rst_rgb", rgba, 0);
        chk("rst_fs", fsa, 0);
        chk("rst_b_hsync", hsb, 1);
        chk("rst_b_vsync", vsb, 1);
        rst = 1'b0;
        step(1);
        chk("post_rst_h", ha, 1);
        chk("post_rst_v", va, 0);
        chk("post_rst_fs", fsa, 0);
        chk("post_rst_b_h", hb, 1);

        // Horizontal timing, line 0
        wait_a(1023, 0, 2000);
        chk("hblnk_1023", hba, 0);
        step(1);
        chk("hblnk_1024", hba, 1);
        wait_a(1047, 0, 100);
        chk("hsync_1047", hsa, 0);
        step(1);
        chk("hsync_1048", hsa, 1);
        t0 = cyc;
        n = 0;
        while (hsa == 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("hsync_width", n, 136);
        chk("hsync_fall_h", ha, 1184);
        wait_a(1047, 1, 2000);
        chk("hsync_l1_1047", hsa, 0);
        step(1);
        t1 = cyc;
        chk("hsync_l1_1048", hsa, 1);
        chk("hsync_period", t1 - t0, 1344);

        // Line wrap on line 10
        wait_a(1343, 10, 20000);
        chk("wrap_hblnk_pre", hba, 1);
        step(1);
        chk("wrap_h", ha, 0);
        chk("wrap_v", va, 11);
        chk("wrap_hblnk", hba, 0);

        // Small raster: vertical timing and frame wrap (active-low syncs)
        wait_b(24, 5, 400);
        chk("b_vblnk_pre", vbb, 0);
        step(1);
        chk("b_vblnk_rise", vbb, 1);
        chk("b_vblnk_h", hb, 0);
        wait_b(24, 6, 400);
        chk("b_vsync_pre", vsb, 1);
        step(1);
        chk("b_vsync_on", vsb, 0);
        n = 0;
        while (vsb == 1'b0 && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("b_vsync_width", n, 50);
        chk("b_vsync_end_v", vb, 9);
        wait_b(24, 11, 400);
        chk("b_fs_pre", fsb, 0);
        chk("b_vblnk_last", vbb, 1);
        step(1);
        chk("b_fwrap_h", hb, 0);
        chk("b_fwrap_v", vb, 0);
        chk("b_fs", fsb, 1);
        chk("b_vblnk_clr", vbb, 0);
        t0 = cyc;
        step(1);
        chk("b_fs_1clk", fsb, 0);
        n = 0;
        while (fsb == 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        t1 = cyc;
        chk("b_fs_period", t1 - t0, 300);
        wait_b(17, 0, 400);
        chk("b_hsync_17", hsb, 1);
        step(1);
        chk("b_hsync_18", hsb, 0);
        wait_b(20, 0, 400);
        chk("b_hsync_20", hsb, 0);
        step(1);
        chk("b_hsync_21", hsb, 1);

        // Mid-frame reset, one clock
        wait_a(499, 12, 5000);
        rst = 1'b1;
        step(1);
        chk("mrst_h", ha, 0);
        chk("mrst_v", va, 0);
        chk("mrst_hsync", hsa, 0);
        chk("mrst_fs", fsa, 0);
        rst = 1'b0;
        step(1);
        chk("mrst_next_h", ha, 1);
        chk("mrst_next_v", va, 0);

        // Scan a full restarted line: syncs and blanking only where they belong
        bad = 0;
        for (int i = 0; i < 1344; i++) begin
            if (hsa !== (ha >= 11'd1048 && ha < 11'd1184)) bad++;
            if (hba !== (ha >= 11'd1024)) bad++;
            if (rgba !== 12'h000 || vba !== 1'b0 || vsa !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("line_scan_bad", bad, 0);
        chk("line_scan_end_v", va, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Source end of the vga_if stream. Generates the raster position counters, sync pulses and blanking flags for 1024x768 @ 60 Hz (65 MHz pixel clock).
- Drives the vga_if.in port of draw_bg and every later drawing stage in the pipeline.
- All outputs are registered. rgb is always driven to 0, so downstream stages own all colour.

Parameters:
- H_ACTIVE, 1024, visible pixels per line (equals HOR_PIXELS from vga_pkg)
- H_FP, 24, horizontal front porch, in clocks
- H_SYNC, 136, horizontal sync width, in clocks
- H_BP, 160, horizontal back porch, in clocks
- V_ACTIVE, 768, visible lines per frame (equals VER_PIXELS from vga_pkg)
- V_FP, 3, vertical front porch, in lines
- V_SYNC, 6, vertical sync width, in lines
- V_BP, 29, vertical back porch, in lines
- SYNC_POL, 1, asserted level of hsync/vsync (1 = active-high)

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst  in  1  synchronous, active-high reset
- vga_out  vga_if.out  -  drives hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]
- frame_start  out  1  one-clock pulse while hcount==0 and vcount==0

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1344
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 806
- Counter widths: 11 bits each. Elaboration-time assertion that H_TOTAL-1 and V_TOTAL-1 fit in 11 bits.
- Reset (sync, active-high, overrides everything):
  - hcount=0, vcount=0
  - hblnk=0, vblnk=0
  - hsync=vsync=~SYNC_POL (deasserted)
  - rgb=0
  - frame_start=0
- First clock after rst falls: outputs show hcount=1, vcount=0.
- Counting:
  - hcount_nxt = (hcount==H_TOTAL-1) ? 0 : hcount+1.
  - vcount changes only when hcount wraps: vcount_nxt = (vcount==V_TOTAL-1) ? 0 : vcount+1; otherwise vcount holds.
  - Simultaneous wrap at (1343,805) goes to (0,0).
- Decode from the next counter values, registered with them. Every output flag therefore matches the hcount/vcount presented in the same cycle, with zero skew between fields.
  - hblnk = (hcount >= H_ACTIVE), i.e. 1024..1343
  - hsync asserted for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 1048..1183
  - vblnk = (vcount >= V_ACTIVE), i.e. 768..805, for the whole of each such line
  - vsync asserted for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 771..776, for the whole of each such line including its hblnk portion
  - frame_start = (hcount_nxt==0 && vcount_nxt==0), registered. The pulse therefore coincides with output (0,0).
- Values that never appear on the outputs: hcount > 1343, vcount > 805.
- Period checks:
  - hsync period = 1344 clocks
  - vsync period = 1344*806 = 1083264 clocks
  - frame_start period = 1083264 clocks
- Reset mid-frame: the next output after rst deasserts is (1,0). No partial sync pulse is held, because sync returns to the deasserted level during reset.
- Latency: downstream stages see position (h,v) exactly one clock after it was computed. No handshake: the stream advances every clock.

Test Plan:
- Reset: assert rst 3 clocks at an arbitrary position -> during reset all outputs 0 and syncs deasserted; first cycle after deassert shows hcount=1, vcount=0; frame_start=0.
- Line wrap: run to hcount=1343, vcount=10 -> next cycle hcount=0, vcount=11; hblnk falls 1->0 in the same cycle.
- Horizontal timing on line 0: hblnk rises at hcount=1024; hsync asserts at 1048 and deasserts at 1184 -> exactly 136 asserted clocks; hsync-to-hsync distance = 1344 clocks.
- Vertical timing:
  - vblnk rises at vcount=768 with hcount=0.
  - vsync asserted for vcount 771..776 -> 6*1344 = 8064 contiguous clocks.
  - vblnk clears at (0,0).
- Frame wrap: at (1343,805) -> next cycle (0,0) with frame_start=1 for exactly one clock. Two consecutive frame_start pulses are 1083264 clocks apart.
- Mid-frame reset: pulse rst for 1 clock at (500,400) while vga_out is monitored by a draw_bg instance -> counters restart from (1,0); draw_bg output shows black during the blanking of the restarted frame; no hsync asserted outside 1048..1183.
